// File: rtl/uart_rx_deser.sv
// UART receive deserializer on the oversampling clock: 2-flop line synchroniser,
// 2-of-3 mid-bit voting, runtime frame format, parity/framing/break status.
module uart_rx_deser #(
   parameter int MAX_DATA_BITS = 9,
   parameter int PRESCALE_W    = 6
) (
   input  logic                     i_clk,
   input  logic                     i_arst_n,
   input  logic                     i_rx_in,
   input  logic [PRESCALE_W-1:0]    i_prescale,
   input  logic [3:0]               i_data_bits,
   input  logic [1:0]               i_parity_mode,
   input  logic                     i_stop_bits,
   output logic                     o_active_flag,
   output logic                     o_valid,
   output logic [MAX_DATA_BITS-1:0] o_data,
   output logic                     o_parity_err,
   output logic                     o_frame_err,
   output logic                     o_break_flag
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   localparam logic [PRESCALE_W-1:0] P_MIN  = PRESCALE_W'(8);
   localparam logic [PRESCALE_W-1:0] P_ONE  = PRESCALE_W'(1);
   localparam logic [PRESCALE_W-1:0] P_ZERO = PRESCALE_W'(0);

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   logic                     sync1_q;
   logic                     rx_s_q;
   state_t                   state_q;
   logic [PRESCALE_W-1:0]    cnt_q;
   logic [PRESCALE_W-1:0]    p_q;
   logic [3:0]               n_q;
   logic                     par_en_q;
   logic                     par_odd_q;
   logic                     two_stop_q;
   logic [3:0]               idx_q;
   logic                     stop_idx_q;
   logic                     s0_q;
   logic                     s1_q;
   logic [MAX_DATA_BITS-1:0] shift_q;
   logic                     par_err_acc_q;
   logic                     frame_err_acc_q;
   logic                     nonzero_q;
   logic                     armed_q;
   logic                     active_q;
   logic                     valid_q;
   logic [MAX_DATA_BITS-1:0] data_q;
   logic                     parity_err_q;
   logic                     frame_err_q;
   logic                     break_q;

   logic [PRESCALE_W-1:0]    p_in;
   logic [3:0]               n_in;
   logic [PRESCALE_W-1:0]    center;
   logic [PRESCALE_W-1:0]    cnt_d;
   logic                     bit_end;
   logic                     at_s0;
   logic                     at_s1;
   logic                     at_vote;
   logic                     vote;
   logic                     brk;

   // Config sanitising, bit-timing decode and the mid-bit vote
   always_comb begin
      p_in = (i_prescale < P_MIN) ? P_MIN : i_prescale;
      if ((i_data_bits < 4'd5) || (i_data_bits > 4'(MAX_DATA_BITS))) begin
         n_in = 4'd8;
      end else begin
         n_in = i_data_bits;
      end
      center  = p_q >> 1;
      bit_end = (cnt_q == (p_q - P_ONE));
      cnt_d   = bit_end ? P_ZERO : (cnt_q + P_ONE);
      at_s0   = (cnt_q == (center - P_ONE));
      at_s1   = (cnt_q == center);
      at_vote = (cnt_q == (center + P_ONE));
      vote    = maj3(s0_q, s1_q, rx_s_q);
      brk     = ~(nonzero_q | vote);
   end

   // Two-flop synchroniser, idle-high after reset
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         sync1_q <= 1'b1;
         rx_s_q  <= 1'b1;
      end else begin
         sync1_q <= i_rx_in;
         rx_s_q  <= sync1_q;
      end
   end

   // Frame FSM with registered outputs
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state_q         <= ST_IDLE;
         cnt_q           <= P_ZERO;
         p_q             <= P_MIN;
         n_q             <= 4'd8;
         par_en_q        <= 1'b0;
         par_odd_q       <= 1'b0;
         two_stop_q      <= 1'b0;
         idx_q           <= 4'd0;
         stop_idx_q      <= 1'b0;
         s0_q            <= 1'b1;
         s1_q            <= 1'b1;
         shift_q         <= {MAX_DATA_BITS{1'b0}};
         par_err_acc_q   <= 1'b0;
         frame_err_acc_q <= 1'b0;
         nonzero_q       <= 1'b0;
         armed_q         <= 1'b1;
         active_q        <= 1'b0;
         valid_q         <= 1'b0;
         data_q          <= {MAX_DATA_BITS{1'b0}};
         parity_err_q    <= 1'b0;
         frame_err_q     <= 1'b0;
         break_q         <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (rx_s_q) begin
            armed_q <= 1'b1;
         end
         if (at_s0) begin
            s0_q <= rx_s_q;
         end
         if (at_s1) begin
            s1_q <= rx_s_q;
         end
         case (state_q)
            ST_IDLE: begin
               cnt_q <= P_ZERO;
               // armed_q blocks re-triggering on a line still held low after a break
               if (!rx_s_q && armed_q) begin
                  state_q         <= ST_START;
                  cnt_q           <= P_ONE;
                  active_q        <= 1'b1;
                  p_q             <= p_in;
                  n_q             <= n_in;
                  par_en_q        <= (i_parity_mode == 2'b01) || (i_parity_mode == 2'b10);
                  par_odd_q       <= (i_parity_mode == 2'b10);
                  two_stop_q      <= i_stop_bits;
                  idx_q           <= 4'd0;
                  stop_idx_q      <= 1'b0;
                  shift_q         <= {MAX_DATA_BITS{1'b0}};
                  par_err_acc_q   <= 1'b0;
                  frame_err_acc_q <= 1'b0;
                  nonzero_q       <= 1'b0;
               end
            end
            ST_START: begin
               cnt_q <= cnt_d;
               if (at_vote && vote) begin
                  state_q  <= ST_IDLE;
                  cnt_q    <= P_ZERO;
                  active_q <= 1'b0;
               end else if (bit_end) begin
                  state_q <= ST_DATA;
               end
            end
            ST_DATA: begin
               cnt_q <= cnt_d;
               if (at_vote) begin
                  shift_q[idx_q] <= vote;
                  if (vote) begin
                     nonzero_q <= 1'b1;
                  end
               end
               if (bit_end) begin
                  if (idx_q == (n_q - 4'd1)) begin
                     state_q <= par_en_q ? ST_PARITY : ST_STOP;
                  end else begin
                     idx_q <= idx_q + 4'd1;
                  end
               end
            end
            ST_PARITY: begin
               cnt_q <= cnt_d;
               if (at_vote) begin
                  par_err_acc_q <= vote ^ (^shift_q) ^ par_odd_q;
                  if (vote) begin
                     nonzero_q <= 1'b1;
                  end
               end
               if (bit_end) begin
                  state_q <= ST_STOP;
               end
            end
            ST_STOP: begin
               cnt_q <= cnt_d;
               // The last stop bit completes the frame at its vote, not at the boundary
               if (at_vote && (stop_idx_q == two_stop_q)) begin
                  state_q      <= ST_IDLE;
                  cnt_q        <= P_ZERO;
                  active_q     <= 1'b0;
                  valid_q      <= 1'b1;
                  data_q       <= shift_q;
                  parity_err_q <= par_err_acc_q;
                  frame_err_q  <= frame_err_acc_q | ~vote;
                  break_q      <= brk;
                  if (brk) begin
                     armed_q <= 1'b0;
                  end
               end else begin
                  if (at_vote) begin
                     if (vote) begin
                        nonzero_q <= 1'b1;
                     end else begin
                        frame_err_acc_q <= 1'b1;
                     end
                  end
                  if (bit_end) begin
                     stop_idx_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               cnt_q    <= P_ZERO;
               active_q <= 1'b0;
            end
         endcase
      end
   end

   assign o_active_flag = active_q;
   assign o_valid       = valid_q;
   assign o_data        = data_q;
   assign o_parity_err  = parity_err_q;
   assign o_frame_err   = frame_err_q;
   assign o_break_flag  = break_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: frame formats, parity/framing/break status,
// false start, back-to-back frames and asynchronous reset mid-frame.
module tb_uart_rx_deser;

   logic       i_clk = 1'b0;
   logic       i_arst_n;
   logic       i_rx_in;
   logic [5:0] i_prescale;
   logic [3:0] i_data_bits;
   logic [1:0] i_parity_mode;
   logic       i_stop_bits;
   logic       o_active_flag;
   logic       o_valid;
   logic [8:0] o_data;
   logic       o_parity_err;
   logic       o_frame_err;
   logic       o_break_flag;

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;
   int vcnt       = 0;
   int vcyc_log  [0:15];
   logic [8:0] vdata_log [0:15];
   int rise_cyc   = -1;
   int fall_cyc   = -1;
   logic prev_act = 1'b0;
   int d;
   int d1;

   uart_rx_deser #(.MAX_DATA_BITS(9), .PRESCALE_W(6)) dut (
      .i_clk         (i_clk),
      .i_arst_n      (i_arst_n),
      .i_rx_in       (i_rx_in),
      .i_prescale    (i_prescale),
      .i_data_bits   (i_data_bits),
      .i_parity_mode (i_parity_mode),
      .i_stop_bits   (i_stop_bits),
      .o_active_flag (o_active_flag),
      .o_valid       (o_valid),
      .o_data        (o_data),
      .o_parity_err  (o_parity_err),
      .o_frame_err   (o_frame_err),
      .o_break_flag  (o_break_flag)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   // Log valid pulses and active-flag edges, sampled mid-cycle
   always @(negedge i_clk) begin
      if (o_valid) begin
         if (vcnt < 16) begin
            vcyc_log[vcnt]  = cyc;
            vdata_log[vcnt] = o_data;
         end
         vcnt = vcnt + 1;
      end
      if (o_active_flag && !prev_act) rise_cyc = cyc;
      if (!o_active_flag && prev_act) fall_cyc = cyc;
      prev_act = o_active_flag;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors = vectors + 1;
      assert (obs === exp) else begin
         miscompares = miscompares + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   // Drives bits[0] first, each for p clocks; returns the cycle the first bit was driven
   task automatic send_bits(input logic [15:0] bits, input int nb, input int p, output int d0);
      d0 = cyc;
      for (int i = 0; i < nb; i++) begin
         i_rx_in = bits[i];
         tick(p);
      end
      i_rx_in = 1'b1;
   endtask

   initial begin
      i_arst_n      = 1'b0;
      i_rx_in       = 1'b1;
      i_prescale    = 6'd16;
      i_data_bits   = 4'd8;
      i_parity_mode = 2'b00;
      i_stop_bits   = 1'b0;
      tick(3);
      chk("rst_active", 32'(o_active_flag), 32'd0);
      chk("rst_valid",  32'(o_valid),       32'd0);
      chk("rst_data",   32'(o_data),        32'd0);
      chk("rst_perr",   32'(o_parity_err),  32'd0);
      chk("rst_ferr",   32'(o_frame_err),   32'd0);
      chk("rst_brk",    32'(o_break_flag),  32'd0);
      i_arst_n = 1'b1;
      tick(5);

      // P=16 8N1 0xA5: valid at t+154 = drive+156
      send_bits(16'h034A, 10, 16, d);
      tick(10);
      chk("t1_vcnt",   32'(vcnt),         32'd1);
      chk("t1_vcyc",   32'(vcyc_log[0]),  32'(d + 156));
      chk("t1_data",   32'(o_data),       32'h0A5);
      chk("t1_perr",   32'(o_parity_err), 32'd0);
      chk("t1_ferr",   32'(o_frame_err),  32'd0);
      chk("t1_brk",    32'(o_break_flag), 32'd0);
      chk("t1_rise",   32'(rise_cyc),     32'(d + 3));
      chk("t1_fall",   32'(fall_cyc),     32'(d + 156));

      // P=8 8E1 0x3C with wrong parity bit 1: valid at t+86
      i_prescale    = 6'd8;
      i_parity_mode = 2'b01;
      send_bits(16'h0678, 11, 8, d);
      tick(10);
      chk("t2_vcnt",   32'(vcnt),         32'd2);
      chk("t2_vcyc",   32'(vcyc_log[1]),  32'(d + 88));
      chk("t2_data",   32'(o_data),       32'h03C);
      chk("t2_perr",   32'(o_parity_err), 32'd1);
      chk("t2_ferr",   32'(o_frame_err),  32'd0);

      // P=16 four-cycle glitch: false start, active falls at t+C+2
      i_prescale    = 6'd16;
      i_parity_mode = 2'b00;
      d = cyc;
      i_rx_in = 1'b0;
      tick(4);
      i_rx_in = 1'b1;
      tick(40);
      chk("t3_rise",   32'(rise_cyc),     32'(d + 3));
      chk("t3_fall",   32'(fall_cyc),     32'(d + 12));
      chk("t3_vcnt",   32'(vcnt),         32'd2);
      chk("t3_data",   32'(o_data),       32'h03C);
      chk("t3_perr",   32'(o_parity_err), 32'd1);

      // P=32 7O2 0x55, correct parity, second stop bit low: valid at t+338
      i_prescale    = 6'd32;
      i_data_bits   = 4'd7;
      i_parity_mode = 2'b10;
      i_stop_bits   = 1'b1;
      send_bits(16'h03AA, 11, 32, d);
      tick(120);
      chk("t4_vcnt",   32'(vcnt),         32'd3);
      chk("t4_vcyc",   32'(vcyc_log[2]),  32'(d + 340));
      chk("t4_data",   32'(o_data),       32'h055);
      chk("t4_ferr",   32'(o_frame_err),  32'd1);
      chk("t4_perr",   32'(o_parity_err), 32'd0);
      chk("t4_brk",    32'(o_break_flag), 32'd0);

      // P=16 8N1 line low for 12 bit times: break, no re-trigger while low
      i_prescale    = 6'd16;
      i_data_bits   = 4'd8;
      i_parity_mode = 2'b00;
      i_stop_bits   = 1'b0;
      d = cyc;
      i_rx_in = 1'b0;
      tick(192);
      chk("t5_vcyc",   32'(vcyc_log[3]),  32'(d + 156));
      chk("t5_data",   32'(o_data),       32'h000);
      chk("t5_brk",    32'(o_break_flag), 32'd1);
      chk("t5_ferr",   32'(o_frame_err),  32'd1);
      chk("t5_perr",   32'(o_parity_err), 32'd0);
      chk("t5_active", 32'(o_active_flag), 32'd0);
      i_rx_in = 1'b1;
      tick(40);
      chk("t5_vcnt",   32'(vcnt),         32'd4);

      // Back-to-back 0x12, 0x34 with no idle gap
      send_bits(16'h0224, 10, 16, d1);
      send_bits(16'h0268, 10, 16, d);
      tick(10);
      chk("t6_vcnt",   32'(vcnt),         32'd6);
      chk("t6_vcyc0",  32'(vcyc_log[4]),  32'(d1 + 156));
      chk("t6_gap",    32'(vcyc_log[5] - vcyc_log[4]), 32'd160);
      chk("t6_data0",  32'(vdata_log[4]), 32'h012);
      chk("t6_data1",  32'(vdata_log[5]), 32'h034);

      // Third frame 0x56 aborted by reset during the data bits
      send_bits(16'h02AC, 4, 16, d);
      chk("t7_active", 32'(o_active_flag), 32'd1);
      i_arst_n = 1'b0;
      #1;
      chk("t7_ar_act",  32'(o_active_flag), 32'd0);
      chk("t7_ar_data", 32'(o_data),        32'd0);
      chk("t7_ar_ferr", 32'(o_frame_err),   32'd0);
      chk("t7_ar_perr", 32'(o_parity_err),  32'd0);
      tick(3);
      i_arst_n = 1'b1;
      tick(200);
      chk("t7_vcnt",   32'(vcnt),          32'd6);
      chk("t7_data",   32'(o_data),        32'd0);
      chk("t7_active", 32'(o_active_flag), 32'd0);
      chk("t7_valid",  32'(o_valid),       32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
